perf_event_counter: RTL and testbench
=====================================

// Module: perf_event_counter
// PURPOSE
//  Performance-event counter bank downstream of the multicycle control FSM.
//  Samples the FSM's per-cycle control strobes and op field, classifies each cycle into events
//  (fetch, branch/jump, load, store, addiu, cycle), and keeps one counter per event.
//  Readable by the debug/test harness through a registered select port.
// PARAMETERS
//  WIDTH     32         counter width in bits
//  OP_ADDIU  6'b001001  opcode classed as an addiu event
// PORTS
//  clk          in   1      clock; all state updates on its rising edge
//  rst          in   1      synchronous reset, active-high
//  IRWrite      in   1      FSM fetch-state strobe
//  MemRead      in   1      FSM memory-read strobe
//  MemWrite     in   1      FSM memory-write strobe
//  PCWrite      in   1      FSM unconditional PC write
//  PCWriteCond  in   1      FSM conditional PC write (branch state)
//  RegWrite     in   1      FSM register-file write strobe
//  op           in   6      opcode of instruction currently held in IR
//  cnt_freeze   in   1      1 = all counters hold
//  cnt_clear    in   1      1 = zero all counters and overflow flags
//  cnt_sel      in   3      read select: 0 cyc,1 inst,2 br,3 ld,4 st,5 addiu,6-7 -> 0
//  cnt_rdata    out  WIDTH  selected counter value, registered
//  cnt_ovf      out  6      sticky wrap flags, bit i per counter index i
//  inst, br, ld, st, addiu  out  WIDTH  live counter values (direct taps)
// BEHAVIOUR
//  - Reset: every counter, cnt_ovf and cnt_rdata = 0 on the first clk edge with rst=1.
//  - Event decode, combinational on the current cycle's strobes:
//      ev_cyc   = 1 every cycle
//      ev_inst  = IRWrite
//      ev_br    = PCWriteCond | (PCWrite & ~IRWrite)  (branch, jal, j, jr)
//      ev_ld    = MemRead & ~IRWrite                    (data-read state only)
//      ev_st    = MemWrite
//      ev_addiu = RegWrite & (op == OP_ADDIU)
//  - Counter update priority per edge: rst > cnt_clear > cnt_freeze > increment on event.
//  - Increment is +1 modulo 2^WIDTH. Wrap (all-ones -> 0) sets that counter's cnt_ovf bit.
//  - cnt_ovf bits are sticky; cleared only by rst or cnt_clear.
//  - cnt_clear and an event in the same cycle: counter = 0, not 1. Event lost.
//  - cnt_freeze=1: counters and ovf hold. Read port still updates.
//  - Read latency 1 cycle: cnt_rdata(t+1) = counter[cnt_sel(t)] as it was before edge t+1's update.
//    Unused selects 6-7 read 0.
//  - Direct taps show the current register values with no added latency.
//  - rst mid-sequence: all state zeroed at that edge; counting resumes the cycle after rst drops.
//  - No state machine besides the counters. No handshake. No back-pressure onto the FSM.
// STRUCTURE
//  - Shared package: counter indices (CNT_CYC..CNT_ADDIU), NUM_CNT=6, opcode constants
//    (OP_LW, OP_SW, OP_ADDIU, OP_BEQ, OP_BNE, OP_J, OP_JAL), also used by the control FSM.
//  - Sub-module perf_cnt_slice (WIDTH): one counter. Inputs en/clr/frz; outputs value and sticky ovf.
//    Instantiated NUM_CNT times. Top level holds the decode and the read mux/register.
// TESTING
//  1. Assert rst 2 cycles mid-count -> all taps, cnt_rdata, cnt_ovf = 0 the next cycle.
//  2. Drive the strobe sequence of lw (fetch, decode, addr, read, wb) -> inst=1, ld=1, st=0, br=0;
//     cycle count (cnt_sel=0) = 5.
//  3. Drive sw, beq, j, jal, addiu (op=001001), lui (op=001111) -> inst=6, st=1, br=3, addiu=1.
//  4. WIDTH=4; run 16 fetch cycles -> inst=0 and cnt_ovf[1]=1. cnt_clear -> ovf=0 next cycle.
//  5. cnt_clear together with IRWrite -> inst=0. cnt_freeze for 3 fetches -> inst unchanged.
//     cnt_sel=6 -> cnt_rdata=0.
//  6. Change cnt_sel every cycle -> cnt_rdata tracks the selected value with exactly 1-cycle lag.

Source files
------------

// File: rtl/perf_event_counter_pkg.sv
// Shared constants for the performance counter bank and the multicycle control FSM.
package perf_event_counter_pkg;

    localparam int NUM_CNT   = 6;

    localparam int CNT_CYC   = 0;
    localparam int CNT_INST  = 1;
    localparam int CNT_BR    = 2;
    localparam int CNT_LD    = 3;
    localparam int CNT_ST    = 4;
    localparam int CNT_ADDIU = 5;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef logic [NUM_CNT-1:0] ev_vec_t;

endpackage

// File: rtl/perf_cnt_slice.sv
// One event counter: clear beats freeze beats increment; wrap sets a sticky overflow flag.
module perf_cnt_slice #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             frz_i,
    output logic [WIDTH-1:0] value_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (!frz_i && en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
            if (&cnt_q) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign value_o = cnt_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/perf_event_counter.sv
// Performance counter bank: classifies each control-FSM cycle into events and counts them.
// Selected counter is returned one cycle later on cnt_rdata; live taps are unregistered.
module perf_event_counter
    import perf_event_counter_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter logic [5:0] OP_ADDIU = 6'b001001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IRWrite,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               PCWrite,
    input  logic               PCWriteCond,
    input  logic               RegWrite,
    input  logic [5:0]         op,
    input  logic               cnt_freeze,
    input  logic               cnt_clear,
    input  logic [2:0]         cnt_sel,
    output logic [WIDTH-1:0]   cnt_rdata,
    output logic [NUM_CNT-1:0] cnt_ovf,
    output logic [WIDTH-1:0]   inst,
    output logic [WIDTH-1:0]   br,
    output logic [WIDTH-1:0]   ld,
    output logic [WIDTH-1:0]   st,
    output logic [WIDTH-1:0]   addiu
);

    ev_vec_t          ev;
    logic [WIDTH-1:0] cnt_val [NUM_CNT];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Fetch also drives MemRead and PCWrite; mask those so only real loads/jumps count.
    always_comb begin
        ev            = '0;
        ev[CNT_CYC]   = 1'b1;
        ev[CNT_INST]  = IRWrite;
        ev[CNT_BR]    = PCWriteCond | (PCWrite & ~IRWrite);
        ev[CNT_LD]    = MemRead & ~IRWrite;
        ev[CNT_ST]    = MemWrite;
        ev[CNT_ADDIU] = RegWrite & (op == OP_ADDIU);
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        perf_cnt_slice #(
            .WIDTH (WIDTH)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .en_i    (ev[i]),
            .clr_i   (cnt_clear),
            .frz_i   (cnt_freeze),
            .value_o (cnt_val[i]),
            .ovf_o   (cnt_ovf[i])
        );
    end

    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (cnt_sel == 3'(i)) rdata_d = cnt_val[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign cnt_rdata = rdata_q;
    assign inst      = cnt_val[CNT_INST];
    assign br        = cnt_val[CNT_BR];
    assign ld        = cnt_val[CNT_LD];
    assign st        = cnt_val[CNT_ST];
    assign addiu     = cnt_val[CNT_ADDIU];

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench for perf_event_counter: directed strobe sequences push expectations; a monitor checks them.
module tb_perf_event_counter;
    import perf_event_counter_pkg::*;

    logic        clk = 1'b0;
    logic        rst, IRWrite, MemRead, MemWrite, PCWrite, PCWriteCond, RegWrite;
    logic [5:0]  op;
    logic        cnt_freeze, cnt_clear;
    logic [2:0]  cnt_sel;

    logic [31:0] cnt_rdata, inst, br, ld, st, addiu;
    logic [5:0]  cnt_ovf;
    logic [3:0]  rdata4, inst4, br4, ld4, st4, addiu4;
    logic [5:0]  ovf4;

    always #5 clk = ~clk;

    perf_event_counter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .op(op),
        .cnt_freeze(cnt_freeze), .cnt_clear(cnt_clear), .cnt_sel(cnt_sel),
        .cnt_rdata(cnt_rdata), .cnt_ovf(cnt_ovf),
        .inst(inst), .br(br), .ld(ld), .st(st), .addiu(addiu)
    );

    perf_event_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .op(op),
        .cnt_freeze(cnt_freeze), .cnt_clear(cnt_clear), .cnt_sel(cnt_sel),
        .cnt_rdata(rdata4), .cnt_ovf(ovf4),
        .inst(inst4), .br(br4), .ld(ld4), .st(st4), .addiu(addiu4)
    );

    typedef enum {S_INST, S_BR, S_LD, S_ST, S_ADDIU, S_RDATA, S_OVF, S_INST4, S_OVF4} sig_e;
    typedef struct {
        int          due;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            S_INST:  return inst;
            S_BR:    return br;
            S_LD:    return ld;
            S_ST:    return st;
            S_ADDIU: return addiu;
            S_RDATA: return cnt_rdata;
            S_OVF:   return {26'd0, cnt_ovf};
            S_INST4: return {28'd0, inst4};
            S_OVF4:  return {26'd0, ovf4};
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: at each falling edge, compare every expectation due after the preceding rising edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e   = sb.pop_front();
                act = sample(e.sig);
                checks++;
                if (act !== e.val || e.due != cyc) begin
                    failures++;
                    $display("FAIL %s: got %0d expected %0d (due %0d, now %0d)",
                             e.name, act, e.val, e.due, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic ir, input logic mr, input logic mw, input logic pw,
                           input logic pwc, input logic rw, input logic [5:0] o);
        IRWrite = ir; MemRead = mr; MemWrite = mw;
        PCWrite = pw; PCWriteCond = pwc; RegWrite = rw; op = o;
    endtask

    // Expected value of a signal after the next rising edge.
    task automatic expect_v(input sig_e s, input logic [31:0] v, input string n);
        exp_t e;
        e.due = cyc + 1; e.sig = s; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic fetch_decode(input logic [5:0] o);
        set_ctl(1, 1, 0, 1, 0, 0, o); tick();
        set_ctl(0, 0, 0, 0, 0, 0, o); tick();
    endtask

    initial begin
        rst = 1'b1; cnt_freeze = 1'b0; cnt_clear = 1'b0; cnt_sel = 3'd0;
        set_ctl(0, 0, 0, 0, 0, 0, 6'd0);
        tick(); tick();

        // Reset in the middle of counting
        rst = 1'b0;
        set_ctl(1, 1, 0, 1, 0, 0, OP_LW);
        tick(); tick();
        expect_v(S_INST, 3, "pre_rst_inst");
        tick();
        rst = 1'b1;
        expect_v(S_INST, 0, "rst_inst");
        expect_v(S_BR, 0, "rst_br");
        expect_v(S_LD, 0, "rst_ld");
        expect_v(S_ST, 0, "rst_st");
        expect_v(S_ADDIU, 0, "rst_addiu");
        expect_v(S_RDATA, 0, "rst_rdata");
        expect_v(S_OVF, 0, "rst_ovf");
        tick();
        expect_v(S_INST, 0, "rst2_inst");
        tick();
        rst = 1'b0;

        // lw: fetch, decode, address, read, writeback
        fetch_decode(OP_LW);
        set_ctl(0, 0, 0, 0, 0, 0, OP_LW); tick();
        set_ctl(0, 1, 0, 0, 0, 0, OP_LW); tick();
        set_ctl(0, 0, 0, 0, 0, 1, OP_LW);
        expect_v(S_INST, 1, "lw_inst");
        expect_v(S_LD, 1, "lw_ld");
        expect_v(S_ST, 0, "lw_st");
        expect_v(S_BR, 0, "lw_br");
        expect_v(S_ADDIU, 0, "lw_addiu");
        tick();
        set_ctl(0, 0, 0, 0, 0, 0, 6'd0);
        expect_v(S_RDATA, 5, "lw_cycles");
        tick();

        // Clear, then sw, beq, j, jal, addiu, lui (21 cycles)
        cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
        fetch_decode(OP_SW);
        set_ctl(0, 0, 0, 0, 0, 0, OP_SW); tick();
        set_ctl(0, 0, 1, 0, 0, 0, OP_SW); tick();
        fetch_decode(OP_BEQ);
        set_ctl(0, 0, 0, 0, 1, 0, OP_BEQ); tick();
        fetch_decode(OP_J);
        set_ctl(0, 0, 0, 1, 0, 0, OP_J); tick();
        fetch_decode(OP_JAL);
        set_ctl(0, 0, 0, 1, 0, 1, OP_JAL); tick();
        fetch_decode(OP_ADDIU);
        set_ctl(0, 0, 0, 0, 0, 0, OP_ADDIU); tick();
        set_ctl(0, 0, 0, 0, 0, 1, OP_ADDIU); tick();
        fetch_decode(6'b001111);
        set_ctl(0, 0, 0, 0, 0, 0, 6'b001111); tick();
        set_ctl(0, 0, 0, 0, 0, 1, 6'b001111);
        expect_v(S_INST, 6, "mix_inst");
        expect_v(S_ST, 1, "mix_st");
        expect_v(S_BR, 3, "mix_br");
        expect_v(S_ADDIU, 1, "mix_addiu");
        expect_v(S_LD, 0, "mix_ld");
        tick();
        set_ctl(0, 0, 0, 0, 0, 0, 6'd0);
        expect_v(S_RDATA, 21, "mix_cycles");
        tick();
        cnt_sel = 3'd2;
        expect_v(S_RDATA, 3, "mix_rd_br");
        tick();

        // 4-bit instance: 16 fetches wrap inst and cyc
        cnt_sel = 3'd0;
        cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
        set_ctl(1, 0, 0, 0, 0, 0, 6'd0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 15) begin
                expect_v(S_INST4, 15, "w4_inst_15");
                expect_v(S_OVF4, 0, "w4_ovf_15");
            end
            if (i == 16) begin
                expect_v(S_INST4, 0, "w4_inst_wrap");
                expect_v(S_OVF4, 6'b000011, "w4_ovf_wrap");
                expect_v(S_OVF, 0, "w32_ovf_clean");
            end
            tick();
        end
        set_ctl(0, 0, 0, 0, 0, 0, 6'd0);
        expect_v(S_OVF4, 6'b000011, "w4_ovf_sticky");
        tick();
        cnt_clear = 1'b1;
        expect_v(S_OVF4, 0, "w4_ovf_clear");
        expect_v(S_INST4, 0, "w4_inst_clear");
        tick();

        // Clear wins over a same-cycle event, then freeze holds
        set_ctl(1, 0, 0, 0, 0, 0, 6'd0);
        expect_v(S_INST, 0, "clr_vs_ev");
        tick();
        cnt_clear = 1'b0;
        expect_v(S_INST, 1, "post_clr_fetch");
        tick();
        cnt_freeze = 1'b1; cnt_sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            expect_v(S_INST, 1, "frz_inst");
            expect_v(S_RDATA, 1, "frz_rdata");
            tick();
        end
        set_ctl(0, 0, 0, 0, 0, 0, 6'd0);
        cnt_sel = 3'd6;
        expect_v(S_RDATA, 0, "sel6_zero");
        tick();
        cnt_sel = 3'd7;
        expect_v(S_RDATA, 0, "sel7_zero");
        tick();

        // Read select changing every cycle: one-cycle lag, pre-update value
        cnt_freeze = 1'b0;
        cnt_sel = 3'd0; expect_v(S_RDATA, 1, "lag_a"); tick();
        cnt_sel = 3'd1; expect_v(S_RDATA, 1, "lag_b"); tick();
        cnt_sel = 3'd0; expect_v(S_RDATA, 3, "lag_c"); tick();
        cnt_sel = 3'd1; set_ctl(1, 0, 0, 0, 0, 0, 6'd0);
        expect_v(S_RDATA, 1, "lag_d");
        expect_v(S_INST, 2, "lag_d_inst");
        tick();
        set_ctl(0, 0, 0, 0, 0, 0, 6'd0);
        cnt_sel = 3'd1; expect_v(S_RDATA, 2, "lag_e"); tick();
        cnt_sel = 3'd0; expect_v(S_RDATA, 6, "lag_f"); tick();

        tick(); tick(); tick();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
